axi_master_cmd_issuer: RTL and testbench
========================================

Name: axi_master_cmd_issuer

Overview:
- Initiator-side counterpart of the slave command FIFO path.
- Accepts byte-granular transfer requests from an internal engine and splits each into AXI4 INCR bursts that never cross a 4 KB boundary.
- Drives them on an AXI master AR or AW channel with valid/ready handshake.
- Allocates AXI IDs from a free pool and returns them when the matching response (R last / B) is reported back.

Parameters:
- IDW, 3, AXI ID width; pool holds 2^IDW IDs.
- CTXW, 9, user/context width carried unchanged to axuser.
- DATA_BYTES, 64, data bus bytes per beat (power of two, 8..128).
- REQW, 16, width of req_bytes.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  issuer can accept a request.
- req_addr  in  64  start byte address; must be DATA_BYTES-aligned.
- req_bytes  in  REQW  length in bytes; nonzero multiple of DATA_BYTES.
- req_user  in  CTXW  context.
- req_done  out  1  one-cycle pulse when the last burst of a request is accepted on AXI.
- m_axi_axid  out  IDW  burst ID.
- m_axi_axaddr  out  64  burst address.
- m_axi_axlen  out  8  beats-1.
- m_axi_axsize  out  3  log2(DATA_BYTES).
- m_axi_axburst  out  2  constant 2'b01 (INCR).
- m_axi_axuser  out  CTXW  req_user of the owning request.
- m_axi_axvalid  out  1  command valid.
- m_axi_axready  in  1  command accepted.
- rsp_valid  in  1  response completed for rsp_id.
- rsp_id  in  IDW  ID to free.
- outstanding  out  IDW+1  number of busy IDs.
- id_err  out  1  sticky; set when rsp_valid names an ID that is not busy.

Behaviour:
- Reset (async, immediate):
  - Outputs: req_ready=0, req_done=0, axvalid=0, outstanding=0, id_err=0.
  - All ax* fields 0, except axsize=log2(DATA_BYTES) and axburst=01.
  - Busy bitmap cleared; FSM to IDLE.
- All AXI outputs are registered.
- FSM states:
  - IDLE:
    - req_ready=1.
    - On req_valid, latch cur_addr=req_addr, remaining=req_bytes, user=req_user; go to CALC.
  - CALC:
    - req_ready=0.
    - to4k = 4096 - cur_addr[11:0].
    - burst = min(remaining, to4k, 256*DATA_BYTES), computed at 13+ bits without truncation.
    - If any ID is free, pick the lowest-index free ID, mark it busy, and register axaddr=cur_addr, axlen=burst/DATA_BYTES-1, axid, axuser. Then cur_addr+=burst, remaining-=burst; go to ISSUE.
    - If no ID is free, stay in CALC with no side effects.
  - ISSUE:
    - axvalid=1; all ax* fields held stable until axready.
    - On axvalid&axready:
      - If remaining==0, pulse req_done and go to IDLE.
      - Otherwise go to CALC.
- Latency: request handshake in cycle N gives first axvalid in cycle N+2. Each further burst needs 1 CALC cycle after the previous burst's acceptance.
- Throughput: one burst per 2 cycles maximum.
- ID release:
  - rsp_valid clears busy[rsp_id].
  - A release and an allocation in the same cycle:
    - Allocation uses the pre-release bitmap; the freed ID is usable next cycle.
    - outstanding is net unchanged if both hit different IDs.
  - Release of the ID being allocated in that same cycle is impossible (that ID was free).
  - rsp_valid on a non-busy ID: bitmap unchanged, id_err set (cleared only by reset).
- outstanding = popcount of the busy bitmap, updated the cycle after the change.
- Illegal requests (unaligned or zero/odd length) are undefined.
- Address wrap above 2^64 is not supported.

Decomposition:
- Shared bridge package:
  - AXI_BURST_INCR constant.
  - 4 KB boundary constant.
  - FSM state enum (IDLE, CALC, ISSUE).
  - axsize function log2 of DATA_BYTES.
- One natural sub-module: axi_id_pool.
  - Contents: busy bitmap, lowest-free priority encoder, alloc/release ports, popcount, id_err.
  - Reusable by the write-side issuer.

Test Plan:
- DATA_BYTES=64; req addr 0x1000, bytes 256 → one burst axaddr=0x1000, axlen=3, axsize=6, axburst=01, axid=0; req_done pulses on acceptance.
- addr 0x0FC0, bytes 128 → two bursts: (0x0FC0, len 0) then (0x1000, len 0); IDs 0 and 1; req_done only after the second.
- addr 0x2000, bytes 0x2000 → two bursts (0x2000, len 63), (0x3000, len 63); outstanding reaches 2.
- IDW=2; five 64 B requests, no responses:
  - IDs 0,1,2,3 issue; fifth stalls in CALC with axvalid=0 and outstanding=4.
  - rsp_id=2 → fifth issues with axid=2.
- axready held low 10 cycles during ISSUE → axvalid stays 1 and all ax* fields are bit-stable; single acceptance on the ready cycle.
- reset asserted while axvalid=1 with 3 IDs busy → axvalid=0 and outstanding=0 without waiting for a clock edge; rsp_valid on id 1 afterwards sets id_err.

Source files
------------

// File: rtl/axi_master_cmd_issuer_pkg.sv
// Shared definitions for the AXI master command issuer and its ID pool:
// burst encoding, the 4 KB boundary, FSM states and the axsize helper.
package axi_master_cmd_issuer_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam int         BOUNDARY_4K    = 4096;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    ISSUE = 2'd2
  } issuer_state_e;

  function automatic logic [2:0] axsizeOf(input int dataBytes);
    return 3'($clog2(dataBytes));
  endfunction

endpackage

// File: rtl/axi_master_cmd_issuer_if.sv
// AXI AR/AW address channel as seen from the initiator (master) and the
// target (slave) side.
interface axi_master_cmd_issuer_if #(
  parameter int IDW  = 3,
  parameter int CTXW = 9
);

  logic [IDW-1:0]  axid;
  logic [63:0]     axaddr;
  logic [7:0]      axlen;
  logic [2:0]      axsize;
  logic [1:0]      axburst;
  logic [CTXW-1:0] axuser;
  logic            axvalid;
  logic            axready;

  modport master (
    output axid, axaddr, axlen, axsize, axburst, axuser, axvalid,
    input  axready
  );

  modport slave (
    input  axid, axaddr, axlen, axsize, axburst, axuser, axvalid,
    output axready
  );

endinterface

// File: rtl/axi_master_cmd_issuer_id_pool.sv
// Free pool of AXI IDs: lowest-free allocation, release by ID, registered
// busy count and a sticky flag for releases of IDs that were not busy.
module axi_id_pool #(
  parameter int IDW = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           alloc_i,
  input  logic           release_i,
  input  logic [IDW-1:0] release_id_i,
  output logic           free_avail_o,
  output logic [IDW-1:0] free_id_o,
  output logic [IDW:0]   outstanding_o,
  output logic           id_err_o
);

  localparam int N = 1 << IDW;

  logic [N-1:0] busy_q, busy_d;
  logic [IDW:0] count_q;
  logic         idErr_q;

  function automatic logic [IDW:0] popcount(input logic [N-1:0] bits);
    logic [IDW:0] cnt;
    cnt = '0;
    for (int i = 0; i < N; i++) cnt = cnt + (IDW+1)'(bits[i]);
    return cnt;
  endfunction

  // Scanning downwards lets the lowest free index win.
  always_comb begin
    free_avail_o = 1'b0;
    free_id_o    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_avail_o = 1'b1;
        free_id_o    = IDW'(i);
      end
    end
  end

  // Allocation is decided on the pre-release bitmap, so an ID freed this
  // cycle only becomes allocatable on the next one.
  always_comb begin
    busy_d = busy_q;
    if (release_i) busy_d[release_id_i] = 1'b0;
    if (alloc_i && free_avail_o) busy_d[free_id_o] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q  <= '0;
      count_q <= '0;
      idErr_q <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      count_q <= popcount(busy_d);
      if (release_i && !busy_q[release_id_i]) idErr_q <= 1'b1;
    end
  end

  assign outstanding_o = count_q;
  assign id_err_o      = idErr_q;

endmodule

// File: rtl/axi_master_cmd_issuer.sv
// Splits byte-granular transfer requests into AXI4 INCR bursts that never
// cross a 4 KB boundary and issues them on an AR/AW channel with pooled IDs.
module axi_master_cmd_issuer #(
  parameter int IDW        = 3,
  parameter int CTXW       = 9,
  parameter int DATA_BYTES = 64,
  parameter int REQW       = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [63:0]              req_addr_i,
  input  logic [REQW-1:0]          req_bytes_i,
  input  logic [CTXW-1:0]          req_user_i,
  output logic                     req_done_o,
  axi_master_cmd_issuer_if.master  m_axi,
  input  logic                     rsp_valid_i,
  input  logic [IDW-1:0]           rsp_id_i,
  output logic [IDW:0]             outstanding_o,
  output logic                     id_err_o
);

  import axi_master_cmd_issuer_pkg::*;

  localparam int          SIZE      = $clog2(DATA_BYTES);
  localparam logic [31:0] MAX_BURST = 32'(256 * DATA_BYTES);

  issuer_state_e   state_q;
  logic [63:0]     curAddr_q;
  logic [REQW-1:0] remaining_q;
  logic [CTXW-1:0] user_q;
  logic            reqReady_q;
  logic            reqDone_q;
  logic [IDW-1:0]  axid_q;
  logic [63:0]     axaddr_q;
  logic [7:0]      axlen_q;
  logic [2:0]      axsize_q;
  logic [1:0]      axburst_q;
  logic [CTXW-1:0] axuser_q;
  logic            axvalid_q;

  logic            freeAvail;
  logic [IDW-1:0]  freeId;
  logic [31:0]     to4k;
  logic [31:0]     burst;

  axi_id_pool #(.IDW(IDW)) u_id_pool (
    .clk           (clk),
    .reset         (reset),
    .alloc_i       (state_q == CALC),
    .release_i     (rsp_valid_i),
    .release_id_i  (rsp_id_i),
    .free_avail_o  (freeAvail),
    .free_id_o     (freeId),
    .outstanding_o (outstanding_o),
    .id_err_o      (id_err_o)
  );

  // Wide arithmetic keeps the 4096-byte and 256-beat limits exact.
  always_comb begin
    to4k  = 32'(BOUNDARY_4K) - {20'd0, curAddr_q[11:0]};
    burst = 32'(remaining_q);
    if (to4k < burst)      burst = to4k;
    if (MAX_BURST < burst) burst = MAX_BURST;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      curAddr_q   <= '0;
      remaining_q <= '0;
      user_q      <= '0;
      reqReady_q  <= 1'b0;
      reqDone_q   <= 1'b0;
      axid_q      <= '0;
      axaddr_q    <= '0;
      axlen_q     <= '0;
      axsize_q    <= axsizeOf(DATA_BYTES);
      axburst_q   <= AXI_BURST_INCR;
      axuser_q    <= '0;
      axvalid_q   <= 1'b0;
    end else begin
      reqDone_q <= 1'b0;
      case (state_q)
        IDLE: begin
          reqReady_q <= 1'b1;
          if (req_valid_i && reqReady_q) begin
            reqReady_q  <= 1'b0;
            curAddr_q   <= req_addr_i;
            remaining_q <= req_bytes_i;
            user_q      <= req_user_i;
            state_q     <= CALC;
          end
        end
        CALC: begin
          // Without a free ID the FSM simply waits here for a release.
          if (freeAvail) begin
            axid_q      <= freeId;
            axaddr_q    <= curAddr_q;
            axlen_q     <= 8'((burst >> SIZE) - 32'd1);
            axuser_q    <= user_q;
            axvalid_q   <= 1'b1;
            curAddr_q   <= curAddr_q + 64'(burst);
            remaining_q <= remaining_q - REQW'(burst);
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          if (m_axi.axready) begin
            axvalid_q <= 1'b0;
            if (remaining_q == '0) begin
              reqDone_q  <= 1'b1;
              reqReady_q <= 1'b1;
              state_q    <= IDLE;
            end else begin
              state_q <= CALC;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o     = reqReady_q;
  assign req_done_o      = reqDone_q;
  assign m_axi.axid      = axid_q;
  assign m_axi.axaddr    = axaddr_q;
  assign m_axi.axlen     = axlen_q;
  assign m_axi.axsize    = axsize_q;
  assign m_axi.axburst   = axburst_q;
  assign m_axi.axuser    = axuser_q;
  assign m_axi.axvalid   = axvalid_q;

endmodule

// File: tb/tb_axi_master_cmd_issuer.sv
// Self-checking bench for axi_master_cmd_issuer: directed and random requests
// checked against a burst-splitting and ID-pool model kept in the bench.
module tb_axi_master_cmd_issuer;

  localparam int IDW  = 2;
  localparam int CTXW = 9;
  localparam int DB   = 64;
  localparam int REQW = 16;
  localparam int NID  = 1 << IDW;

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  len;
    bit          last;
  } burst_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            reqValid;
  logic            reqReady;
  logic [63:0]     reqAddr;
  logic [REQW-1:0] reqBytes;
  logic [CTXW-1:0] reqUser;
  logic            reqDone;
  logic            rspValid;
  logic [IDW-1:0]  rspId;
  logic [IDW:0]    outstanding;
  logic            idErr;

  int checks = 0;
  int errors = 0;

  burst_t          expQ[$];
  bit              busyM[NID];
  bit              errM;
  bit              allocPending;
  int              allocId;
  logic [CTXW-1:0] curUser;

  axi_master_cmd_issuer_if #(.IDW(IDW), .CTXW(CTXW)) axIf ();

  axi_master_cmd_issuer #(
    .IDW(IDW), .CTXW(CTXW), .DATA_BYTES(DB), .REQW(REQW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid_i   (reqValid),
    .req_ready_o   (reqReady),
    .req_addr_i    (reqAddr),
    .req_bytes_i   (reqBytes),
    .req_user_i    (reqUser),
    .req_done_o    (reqDone),
    .m_axi         (axIf),
    .rsp_valid_i   (rspValid),
    .rsp_id_i      (rspId),
    .outstanding_o (outstanding),
    .id_err_o      (idErr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int popM();
    int c = 0;
    for (int i = 0; i < NID; i++) c += int'(busyM[i]);
    return c;
  endfunction

  // Model allocation: lowest free ID, or wait for a release.
  function automatic void modelAlloc();
    allocPending = 1'b1;
    for (int i = 0; i < NID; i++) begin
      if (allocPending && !busyM[i]) begin
        busyM[i]     = 1'b1;
        allocId      = i;
        allocPending = 1'b0;
      end
    end
  endfunction

  function automatic void buildBursts(input logic [63:0] addr, input int bytes);
    longint unsigned a, rem, b, to4k;
    burst_t e;
    a   = addr;
    rem = longint'(bytes);
    while (rem > 0) begin
      to4k = 4096 - (a % 4096);
      b = rem;
      if (to4k < b) b = to4k;
      if (256 * DB < b) b = 256 * DB;
      e.addr = a;
      e.len  = 8'(b / DB - 1);
      e.last = (rem == b);
      expQ.push_back(e);
      a   += b;
      rem -= b;
    end
  endfunction

  task automatic respond(input int id);
    rspValid = 1'b1;
    rspId    = IDW'(id);
    @(negedge clk);
    rspValid = 1'b0;
    if (busyM[id]) busyM[id] = 1'b0;
    else           errM      = 1'b1;
    checkOutput("id_err", 64'(idErr), 64'(errM));
    checkOutput("outstanding_release", 64'(outstanding), 64'(popM()));
    if (allocPending) modelAlloc();
  endtask

  task automatic releaseAll();
    for (int i = 0; i < NID; i++) if (busyM[i]) respond(i);
  endtask

  task automatic applyStimulus(input logic [63:0] addr, input int bytes, input logic [CTXW-1:0] user);
    int n = 0;
    while (!reqReady && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("req_ready", 64'(reqReady), 64'd1);
    reqValid = 1'b1;
    reqAddr  = addr;
    reqBytes = REQW'(bytes);
    reqUser  = user;
    @(negedge clk);
    reqValid = 1'b0;
    checkOutput("req_ready_drop", 64'(reqReady), 64'd0);
    curUser = user;
    buildBursts(addr, bytes);
    modelAlloc();
  endtask

  task automatic serveBurst(input int hold, input bit checkLat, input bit releaseAfter);
    burst_t e;
    int n = 0;
    int acceptedId;
    e = expQ.pop_front();
    while (!axIf.axvalid && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("axvalid", 64'(axIf.axvalid), 64'd1);
    if (checkLat) checkOutput("latency", 64'(n), 64'd1);
    acceptedId = allocId;
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) begin
        @(negedge clk);
        checkOutput("axvalid_hold", 64'(axIf.axvalid), 64'd1);
      end
      checkOutput("axaddr", axIf.axaddr, e.addr);
      checkOutput("axlen", 64'(axIf.axlen), 64'(e.len));
      checkOutput("axid", 64'(axIf.axid), 64'(acceptedId));
      checkOutput("axuser", 64'(axIf.axuser), 64'(curUser));
      checkOutput("axsize", 64'(axIf.axsize), 64'd6);
      checkOutput("axburst", 64'(axIf.axburst), 64'd1);
    end
    axIf.axready = 1'b1;
    @(negedge clk);
    axIf.axready = 1'b0;
    checkOutput("axvalid_after_accept", 64'(axIf.axvalid), 64'd0);
    checkOutput("req_done", 64'(reqDone), 64'(e.last));
    checkOutput("outstanding", 64'(outstanding), 64'(popM()));
    if (!e.last) modelAlloc();
    if (releaseAfter) respond(acceptedId);
  endtask

  initial begin
    reset        = 1'b1;
    reqValid     = 1'b0;
    reqAddr      = '0;
    reqBytes     = '0;
    reqUser      = '0;
    rspValid     = 1'b0;
    rspId        = '0;
    axIf.axready = 1'b0;
    errM         = 1'b0;
    allocPending = 1'b0;
    allocId      = 0;
    curUser      = '0;
    for (int i = 0; i < NID; i++) busyM[i] = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("rst_req_ready", 64'(reqReady), 64'd0);
    checkOutput("rst_axvalid", 64'(axIf.axvalid), 64'd0);
    checkOutput("rst_outstanding", 64'(outstanding), 64'd0);
    checkOutput("rst_id_err", 64'(idErr), 64'd0);
    checkOutput("rst_axsize", 64'(axIf.axsize), 64'd6);
    checkOutput("rst_axburst", 64'(axIf.axburst), 64'd1);
    checkOutput("rst_axaddr", axIf.axaddr, 64'd0);
    checkOutput("rst_req_done", 64'(reqDone), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_reset", 64'(reqReady), 64'd1);

    $display("[TB] single burst at 0x1000");
    applyStimulus(64'h1000, 256, 9'h155);
    serveBurst(0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("req_done_pulse_end", 64'(reqDone), 64'd0);
    releaseAll();

    $display("[TB] 4 KB crossing at 0x0FC0");
    applyStimulus(64'h0FC0, 128, 9'h0AA);
    serveBurst(0, 1'b1, 1'b0);
    serveBurst(0, 1'b1, 1'b0);
    releaseAll();

    $display("[TB] two full 4 KB bursts at 0x2000");
    applyStimulus(64'h2000, 'h2000, 9'h1F0);
    serveBurst(0, 1'b1, 1'b0);
    serveBurst(0, 1'b1, 1'b0);
    releaseAll();

    $display("[TB] axready held low for 10 cycles");
    applyStimulus(64'h5000, 192, 9'h033);
    serveBurst(10, 1'b1, 1'b0);
    releaseAll();

    $display("[TB] ID pool exhaustion");
    for (int i = 0; i < NID; i++) begin
      applyStimulus(64'hA000 + 64'(i * DB), DB, CTXW'(i));
      serveBurst(0, 1'b1, 1'b0);
    end
    applyStimulus(64'hB000, DB, 9'h0FF);
    repeat (5) @(negedge clk);
    checkOutput("stall_axvalid", 64'(axIf.axvalid), 64'd0);
    checkOutput("stall_outstanding", 64'(outstanding), 64'(NID));
    respond(2);
    serveBurst(0, 1'b0, 1'b0);
    releaseAll();

    $display("[TB] random requests with overlapping releases");
    for (int r = 0; r < 8; r++) begin
      bit first = 1'b1;
      applyStimulus(64'($urandom_range(0, 65535)) << 6,
                    int'($urandom_range(1, 600)) * DB, CTXW'($urandom));
      while (expQ.size() > 0) begin
        serveBurst(int'($urandom_range(0, 3)), first, 1'b1);
        first = 1'b0;
      end
    end
    releaseAll();
    checkOutput("id_err_clean", 64'(idErr), 64'd0);

    $display("[TB] asynchronous reset with IDs busy");
    applyStimulus(64'h8000, DB, 9'h011);
    serveBurst(0, 1'b1, 1'b0);
    applyStimulus(64'h8040, DB, 9'h022);
    serveBurst(0, 1'b1, 1'b0);
    applyStimulus(64'h9000, DB, 9'h044);
    @(negedge clk);
    checkOutput("pre_rst_axvalid", 64'(axIf.axvalid), 64'd1);
    checkOutput("pre_rst_axid", 64'(axIf.axid), 64'd2);
    checkOutput("pre_rst_outstanding", 64'(outstanding), 64'd3);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_axvalid", 64'(axIf.axvalid), 64'd0);
    checkOutput("async_outstanding", 64'(outstanding), 64'd0);
    checkOutput("async_req_ready", 64'(reqReady), 64'd0);
    checkOutput("async_axaddr", axIf.axaddr, 64'd0);
    checkOutput("async_axid", 64'(axIf.axid), 64'd0);
    checkOutput("async_axuser", 64'(axIf.axuser), 64'd0);
    checkOutput("async_axsize", 64'(axIf.axsize), 64'd6);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < NID; i++) busyM[i] = 1'b0;
    errM         = 1'b0;
    allocPending = 1'b0;
    expQ.delete();
    @(negedge clk);
    checkOutput("ready_after_async", 64'(reqReady), 64'd1);
    respond(1);
    repeat (3) @(negedge clk);
    checkOutput("id_err_sticky", 64'(idErr), 64'd1);
    checkOutput("outstanding_after_err", 64'(outstanding), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
